// File: rtl/range_pkg.sv
// range_pkg: shared types and constants for the range-stream transmitter.
//   tx_state_t    - transmitter FSM states (IDLE, BODY, SOLO_FIN, GAP)
//   tx_entry_t    - one buffered sample with its end-of-frame flag
//   DEFAULT_WIDTH - default sample width, matching the range finder datapath
package range_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BODY     = 2'd1,
    SOLO_FIN = 2'd2,
    GAP      = 2'd3
  } tx_state_t;

  typedef struct packed {
    logic                     last;
    logic [DEFAULT_WIDTH-1:0] data;
  } tx_entry_t;

endpackage

// File: rtl/range_tx_fifo.sv
// range_tx_fifo: synchronous show-ahead FIFO of {last, data} entries.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (empties the FIFO)
//   push, din   - write request and entry ({last, data}); ignored when full
//   pop, dout   - read request and head entry (valid whenever !empty)
//   full, empty - occupancy flags derived from count
//   count       - current occupancy, 0..DEPTH
module range_tx_fifo
  import range_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [WIDTH:0] din,
  input  logic          pop,
  output logic [WIDTH:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [WIDTH:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == CW'(0));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally; occupancy count decides full/empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/range_frame_tx.sv
// range_frame_tx: transmit side of the go/finish range-stream protocol.
// Samples are buffered with a last flag; a frame is launched only once it is
// completely buffered, then sent with go on the first sample, finish on the
// last, and one idle gap cycle before the next frame.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   wr_valid/wr_ready   - upstream handshake (wr_ready = !full)
//   wr_data, wr_last    - sample and its end-of-frame flag
//   data_out, go, finish- registered stream to the range finder
//   busy                - high from the go cycle through the gap cycle
//   frame_cnt           - complete frames currently buffered
//   trunc               - sticky: a frame was force-terminated on overflow
// Optional macro RANGE_TX_EXPECT_EN adds exp_range/exp_valid: the expected
// max-min of each frame, presented in its finish cycle.
module range_frame_tx
  import range_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         wr_last,
  output logic [WIDTH-1:0]             data_out,
  output logic                         go,
  output logic                         finish,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   frame_cnt,
  output logic                         trunc
`ifdef RANGE_TX_EXPECT_EN
  ,
  output logic [WIDTH-1:0]             exp_range,
  output logic                         exp_valid
`endif
);

  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_BODY     = BODY;
  localparam logic [1:0] ST_SOLO_FIN = SOLO_FIN;
  localparam logic [1:0] ST_GAP      = GAP;

  logic [1:0]       state;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   head;
  logic [WIDTH-1:0] head_data;
  logic             head_last;
  logic             wr_fire;
  logic             no_frame;
  logic             force_last;
  logic             eff_last;
  logic             launch;
  logic             pop;
  logic             fin_edge;

  assign wr_ready  = !full;
  assign wr_fire   = wr_valid && !full;
  assign head_data = head[WIDTH-1:0];
  assign head_last = head[WIDTH];

  // In SOLO_FIN the single sample has already left the FIFO but is still
  // counted until its finish edge, so one counted frame means none buffered.
  assign no_frame = (frame_cnt == CW'(0)) ||
                    ((state == ST_SOLO_FIN) && (frame_cnt == CW'(1)));

  // A write that fills the FIFO with no complete frame inside would deadlock;
  // close the frame on that entry instead.
  assign force_last = wr_fire && !pop && (count == CW'(DEPTH-1)) && no_frame;
  assign eff_last   = wr_last || force_last;

  // Launch from IDLE, or straight out of the gap cycle (GAP with finish low).
  assign launch = (frame_cnt != CW'(0)) && !empty &&
                  ((state == ST_IDLE) || ((state == ST_GAP) && !finish));
  assign pop      = launch || (state == ST_BODY);
  assign fin_edge = ((state == ST_BODY) && head_last) || (state == ST_SOLO_FIN);

  range_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_fire),
    .din   ({eff_last, wr_data}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Complete-frame counter and sticky truncation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      trunc     <= 1'b0;
    end else begin
      if (wr_fire && eff_last && !fin_edge) begin
        frame_cnt <= frame_cnt + CW'(1);
      end else if (!(wr_fire && eff_last) && fin_edge) begin
        frame_cnt <= frame_cnt - CW'(1);
      end
      if (force_last && !wr_last) begin
        trunc <= 1'b1;
      end
    end
  end

  // Framing FSM; GAP spans the finish cycle and the following gap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      data_out <= '0;
      go       <= 1'b0;
      finish   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      go     <= 1'b0;
      finish <= 1'b0;
      if (launch) begin
        go       <= 1'b1;
        busy     <= 1'b1;
        data_out <= head_data;
        state    <= head_last ? ST_SOLO_FIN : ST_BODY;
      end else begin
        case (state)
          ST_IDLE: begin
            busy <= 1'b0;
          end
          ST_BODY: begin
            data_out <= head_data;
            if (head_last) begin
              finish <= 1'b1;
              state  <= ST_GAP;
            end
          end
          ST_SOLO_FIN: begin
            finish <= 1'b1;
            state  <= ST_GAP;
          end
          ST_GAP: begin
            if (!finish) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef RANGE_TX_EXPECT_EN
  logic [WIDTH-1:0] run_max;
  logic [WIDTH-1:0] run_min;
  logic [WIDTH-1:0] nx_max;
  logic [WIDTH-1:0] nx_min;

  // Running extremes including the entry being popped this cycle.
  always_comb begin
    nx_max = run_max;
    nx_min = run_min;
    if (head_data > run_max) begin
      nx_max = head_data;
    end else begin
      nx_max = run_max;
    end
    if (head_data < run_min) begin
      nx_min = head_data;
    end else begin
      nx_min = run_min;
    end
  end

  // Expected range reference, presented alongside finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max   <= '0;
      run_min   <= '0;
      exp_range <= '0;
      exp_valid <= 1'b0;
    end else begin
      exp_valid <= 1'b0;
      if (launch) begin
        run_max <= head_data;
        run_min <= head_data;
      end else if (state == ST_BODY) begin
        run_max <= nx_max;
        run_min <= nx_min;
        if (head_last) begin
          exp_valid <= 1'b1;
          exp_range <= nx_max - nx_min;
        end
      end else if (state == ST_SOLO_FIN) begin
        exp_valid <= 1'b1;
        exp_range <= run_max - run_min;
      end
    end
  end
`endif

endmodule
